// File: rtl/duram_port.sv
// duram_port: registered read-data stage for one port of duram_1clk.
// Holds the output register with asynchronous clear. Also holds the bypass mux that
// makes a same-port read-during-write return the data being written.
// Ports:
//   Clk    in   clock, rising edge
//   Reset  in   asynchronous active-low clear of q
//   wren   in   this port writes this cycle
//   wdata  in   this port's write data (bypassed to q on a write)
//   rdata  in   array word at this port's address, pre-edge contents
//   q      out  registered read data
module duram_port #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] q_d;

  // Write-through: the writer sees its own data, even if the other port wins the array.
  always_comb begin
    q_d = rdata;
    if (wren) begin
      q_d = wdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/duram_1clk.sv
// duram_1clk: true dual-port synchronous RAM with a single clock and one shared array.
// Port A is the read-modify-write path, and port B is typically read-only.
// Read data is registered on both ports with one cycle of latency.
// A same-port read-during-write returns the new data.
// A mixed-port read-during-write returns the old data.
// If both ports write one address on the same edge, port A's data is stored.
// Reset clears only the output registers. The array contents are not reset.
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   asynchronous active-low reset (q_a/q_b only)
//   data_a     in   port A write data
//   wren_a     in   port A write enable
//   address_a  in   port A address
//   q_a        out  port A registered read data
//   data_b     in   port B write data
//   wren_b     in   port B write enable
//   address_b  in   port B address
//   q_b        out  port B registered read data
module duram_1clk #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  wren_a,
  input  logic [ADDR_WIDTH-1:0] address_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  wren_b,
  input  logic [ADDR_WIDTH-1:0] address_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_a;
  logic [DATA_WIDTH-1:0] rdata_b;
  logic                  wr_b_ok;

  // B's write is dropped only when A writes the same address this edge.
  assign wr_b_ok = wren_b && !(wren_a && (address_a == address_b));

  // No reset on the array, so it can map onto block RAM.
  always_ff @(posedge Clk) begin
    if (wren_a) begin
      mem[address_a] <= data_a;
    end
    if (wr_b_ok) begin
      mem[address_b] <= data_b;
    end
  end

  // These are pre-edge contents, which gives the old-data result for mixed-port collisions.
  assign rdata_a = mem[address_a];
  assign rdata_b = mem[address_b];

  duram_port #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_a (
    .Clk  (Clk),
    .Reset(Reset),
    .wren (wren_a),
    .wdata(data_a),
    .rdata(rdata_a),
    .q    (q_a)
  );

  duram_port #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_b (
    .Clk  (Clk),
    .Reset(Reset),
    .wren (wren_b),
    .wdata(data_b),
    .rdata(rdata_b),
    .q    (q_b)
  );

endmodule

// File: tb/tb_duram_1clk.sv
// Directed bench for duram_1clk. Inputs change 1 time unit after a rising edge.
// Outputs are sampled at that same point.
module tb_duram_1clk;

  localparam int DW = 32;
  localparam int AW = 6;

  logic          Clk;
  logic          Reset;
  logic [DW-1:0] data_a;
  logic          wren_a;
  logic [AW-1:0] address_a;
  logic [DW-1:0] q_a;
  logic [DW-1:0] data_b;
  logic          wren_b;
  logic [AW-1:0] address_b;
  logic [DW-1:0] q_b;

  int n_checks = 0;
  int n_fail   = 0;

  duram_1clk #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .data_a   (data_a),
    .wren_a   (wren_a),
    .address_a(address_a),
    .q_a      (q_a),
    .data_b   (data_b),
    .wren_b   (wren_b),
    .address_b(address_b),
    .q_b      (q_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset held low with random inputs, writes disabled.
    Reset     = 1'b0;
    wren_a    = 1'b0;
    wren_b    = 1'b0;
    data_a    = $urandom;
    data_b    = $urandom;
    address_a = AW'($urandom);
    address_b = AW'($urandom);
    tick();
    data_a    = $urandom;
    address_b = AW'($urandom);
    tick();
    check("reset_q_a", q_a, 32'h0);
    check("reset_q_b", q_b, 32'h0);
    Reset = 1'b1;

    // Write on A, then read the same word back on B.
    wren_a = 1'b1; address_a = 6'd5; data_a = 32'hDEAD_BEEF; address_b = 6'd0;
    tick();
    check("wr_a5_thru_q_a", q_a, 32'hDEAD_BEEF);
    wren_a = 1'b0; address_b = 6'd5;
    tick();
    check("rd_b5", q_b, 32'hDEAD_BEEF);
    check("rd_a5", q_a, 32'hDEAD_BEEF);

    // Same-port write-through.
    wren_a = 1'b1; address_a = 6'd3; data_a = 32'h1234_5678;
    tick();
    check("wr_a3_thru_q_a", q_a, 32'h1234_5678);

    // Mixed collision: A writes 7 while B reads 7, so B sees old data first.
    wren_a = 1'b1; address_a = 6'd7; data_a = 32'h1;
    tick();
    data_a = 32'h2; address_b = 6'd7;
    tick();
    check("mix_a_wr_q_b_old", q_b, 32'h1);
    check("mix_a_wr_q_a_new", q_a, 32'h2);
    wren_a = 1'b0;
    tick();
    check("mix_a_wr_q_b_next", q_b, 32'h2);

    // Symmetric case: B writes 8 while A reads 8.
    wren_b = 1'b1; address_b = 6'd8; data_b = 32'h33;
    tick();
    check("wr_b8_thru_q_b", q_b, 32'h33);
    data_b = 32'h44; address_a = 6'd8;
    tick();
    check("mix_b_wr_q_a_old", q_a, 32'h33);
    check("mix_b_wr_q_b_new", q_b, 32'h44);
    wren_b = 1'b0;
    tick();
    check("mix_b_wr_q_a_next", q_a, 32'h44);

    // Dual write to the same address: A wins the array, and each q shows its own data.
    wren_a = 1'b1; wren_b = 1'b1; address_a = 6'd9; address_b = 6'd9;
    data_a = 32'hAAAA_AAAA; data_b = 32'h5555_5555;
    tick();
    check("dual_wr_q_a", q_a, 32'hAAAA_AAAA);
    check("dual_wr_q_b", q_b, 32'h5555_5555);
    wren_a = 1'b0; wren_b = 1'b0;
    tick();
    check("dual_rd_q_a", q_a, 32'hAAAA_AAAA);
    check("dual_rd_q_b", q_b, 32'hAAAA_AAAA);

    // Async reset between edges clears q, keeps contents, and reads resume after release.
    address_a = 6'd5; address_b = 6'd3;
    #2;
    Reset = 1'b0;
    #1;
    check("async_rst_q_a", q_a, 32'h0);
    check("async_rst_q_b", q_b, 32'h0);
    data_a = $urandom; data_b = $urandom;
    tick();
    check("held_rst_q_a", q_a, 32'h0);
    check("held_rst_q_b", q_b, 32'h0);
    Reset = 1'b1;
    tick();
    check("post_rst_rd_a5", q_a, 32'hDEAD_BEEF);
    check("post_rst_rd_b3", q_b, 32'h1234_5678);

    // Sweep: write ~addr everywhere via A, then read everything via B with a reset mid-sweep.
    wren_a = 1'b1;
    for (int i = 0; i < 64; i++) begin
      address_a = AW'(i);
      data_a    = ~DW'(i);
      tick();
    end
    wren_a = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i == 32) begin
        #2;
        Reset = 1'b0;
        #1;
        check("sweep_rst_q_b", q_b, 32'h0);
        tick();
        Reset = 1'b1;
      end
      address_b = AW'(i);
      tick();
      check($sformatf("sweep_rd_b%0d", i), q_b, ~DW'(i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
